// File: rtl/apu_cluster_arbiter.sv
// apu_cluster_arbiter: shares NB_UNITS APU units among NB_CORES cores with per-unit round-robin,
// request locking, in-order tag FIFOs and collision-free response routing.
module apu_cluster_arbiter #(
    parameter int NB_CORES        = 8,
    parameter int NB_UNITS        = 5,
    parameter int WAPUTYPE        = (NB_UNITS > 1) ? $clog2(NB_UNITS) : 1,
    parameter int NARGS           = 3,
    parameter int WARG            = 32,
    parameter int WOP             = 6,
    parameter int NDSFLAGS        = 15,
    parameter int NUSFLAGS        = 5,
    parameter int WRESULT         = 32,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NB_CORES-1:0]                 core_req_i,
    input  logic [NB_CORES*WAPUTYPE-1:0]        core_type_i,
    input  logic [NB_CORES*WOP-1:0]             core_op_i,
    input  logic [NB_CORES*NARGS*WARG-1:0]      core_operands_i,
    input  logic [NB_CORES*NDSFLAGS-1:0]        core_flags_i,
    output logic [NB_CORES-1:0]                 core_gnt_o,
    output logic [NB_CORES-1:0]                 core_rvalid_o,
    output logic [NB_CORES*WRESULT-1:0]         core_result_o,
    output logic [NB_CORES*NUSFLAGS-1:0]        core_rflags_o,
    output logic [NB_UNITS-1:0]                 unit_req_o,
    output logic [NB_UNITS*WOP-1:0]             unit_op_o,
    output logic [NB_UNITS*NARGS*WARG-1:0]      unit_operands_o,
    output logic [NB_UNITS*NDSFLAGS-1:0]        unit_flags_o,
    input  logic [NB_UNITS-1:0]                 unit_gnt_i,
    input  logic [NB_UNITS-1:0]                 unit_rvalid_i,
    output logic [NB_UNITS-1:0]                 unit_rready_o,
    input  logic [NB_UNITS*WRESULT-1:0]         unit_result_i,
    input  logic [NB_UNITS*NUSFLAGS-1:0]        unit_rflags_i,
    output logic                                err_o
);
    localparam int WCORE = (NB_CORES > 1) ? $clog2(NB_CORES) : 1;
    localparam int WF = $clog2(MAX_OUTSTANDING);
    localparam int WOPS = NARGS * WARG;
    localparam logic [WF:0] FULL_CNT = (WF+1)'(MAX_OUTSTANDING);
    localparam logic [WCORE-1:0] LAST = WCORE'(NB_CORES - 1);

    logic [NB_CORES-1:0] cand [NB_UNITS];
    logic [WCORE-1:0]    ptr [NB_UNITS];
    logic [WCORE-1:0]    lock_core [NB_UNITS];
    logic [WCORE-1:0]    win [NB_UNITS];
    logic [WCORE-1:0]    head [NB_UNITS];
    logic [WCORE-1:0]    fifo [NB_UNITS][MAX_OUTSTANDING];
    logic [WF-1:0]       wr_ptr [NB_UNITS];
    logic [WF-1:0]       rd_ptr [NB_UNITS];
    logic [WF:0]         cnt [NB_UNITS];
    logic [NB_UNITS-1:0] locked, found, push, pop, busy;

    function automatic logic [WCORE-1:0] rr_idx(input logic [WCORE-1:0] p, input int k);
        int i;
        i = int'(p) + k;
        return WCORE'((i >= NB_CORES) ? i - NB_CORES : i);
    endfunction

    always_comb begin
        for (int u = 0; u < NB_UNITS; u++)
            for (int c = 0; c < NB_CORES; c++)
                cand[u][c] = core_req_i[c] && (core_type_i[c*WAPUTYPE +: WAPUTYPE] == WAPUTYPE'(u));
    end

    // A locked unit keeps its stalled winner; otherwise the descending scan leaves the first candidate at/after ptr.
    always_comb begin
        unit_req_o      = '0;
        unit_op_o       = '0;
        unit_operands_o = '0;
        unit_flags_o    = '0;
        core_gnt_o      = '0;
        push            = '0;
        for (int u = 0; u < NB_UNITS; u++) begin
            win[u]   = lock_core[u];
            found[u] = locked[u] && cand[u][lock_core[u]];
            for (int k = NB_CORES - 1; k >= 0; k--)
                if (!locked[u] && cand[u][rr_idx(ptr[u], k)]) begin
                    win[u]   = rr_idx(ptr[u], k);
                    found[u] = 1'b1;
                end
            unit_req_o[u] = found[u] && (cnt[u] != FULL_CNT) && !rst_i;
            if (unit_req_o[u]) begin
                unit_op_o[u*WOP +: WOP]              = core_op_i[win[u]*WOP +: WOP];
                unit_operands_o[u*WOPS +: WOPS]      = core_operands_i[win[u]*WOPS +: WOPS];
                unit_flags_o[u*NDSFLAGS +: NDSFLAGS] = core_flags_i[win[u]*NDSFLAGS +: NDSFLAGS];
            end
            push[u] = unit_req_o[u] && unit_gnt_i[u];
            if (push[u])
                core_gnt_o[win[u]] = 1'b1;
        end
    end

    // Two units answering the same core in one cycle: lowest unit index goes first.
    always_comb begin
        for (int u = 0; u < NB_UNITS; u++) begin
            head[u] = fifo[u][rd_ptr[u]];
            busy[u] = cnt[u] != '0;
        end
        for (int u = 0; u < NB_UNITS; u++) begin
            unit_rready_o[u] = !rst_i;
            for (int v = 0; v < u; v++)
                if (unit_rvalid_i[v] && busy[v] && busy[u] && head[v] == head[u])
                    unit_rready_o[u] = 1'b0;
            pop[u] = unit_rvalid_i[u] && unit_rready_o[u] && busy[u];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int u = 0; u < NB_UNITS; u++) begin
                ptr[u]       <= '0;
                lock_core[u] <= '0;
                wr_ptr[u]    <= '0;
                rd_ptr[u]    <= '0;
                cnt[u]       <= '0;
            end
            locked        <= '0;
            core_rvalid_o <= '0;
            core_result_o <= '0;
            core_rflags_o <= '0;
            err_o         <= 1'b0;
        end else begin
            core_rvalid_o <= '0;
            for (int u = 0; u < NB_UNITS; u++) begin
                if (push[u]) begin
                    ptr[u]    <= (win[u] == LAST) ? '0 : win[u] + 1'b1;
                    locked[u] <= 1'b0;
                    wr_ptr[u] <= wr_ptr[u] + 1'b1;
                end else if (unit_req_o[u]) begin
                    locked[u]    <= 1'b1;
                    lock_core[u] <= win[u];
                end
                if (pop[u]) begin
                    rd_ptr[u]                                     <= rd_ptr[u] + 1'b1;
                    core_rvalid_o[head[u]]                        <= 1'b1;
                    core_result_o[head[u]*WRESULT +: WRESULT]     <= unit_result_i[u*WRESULT +: WRESULT];
                    core_rflags_o[head[u]*NUSFLAGS +: NUSFLAGS]   <= unit_rflags_i[u*NUSFLAGS +: NUSFLAGS];
                end
                if (unit_rvalid_i[u] && !busy[u])
                    err_o <= 1'b1;
                cnt[u] <= cnt[u] + (WF+1)'(push[u]) - (WF+1)'(pop[u]);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        for (int u = 0; u < NB_UNITS; u++)
            if (push[u])
                fifo[u][wr_ptr[u]] <= win[u];
        for (int c = 0; c < NB_CORES; c++)
            assert (rst_i || !core_req_i[c] || int'(core_type_i[c*WAPUTYPE +: WAPUTYPE]) < NB_UNITS);
    end
endmodule

// File: tb/tb_apu_cluster_arbiter.sv
// tb_apu_cluster_arbiter: directed checks of arbitration, locking, FIFO limits, collisions, errors and reset.
module tb_apu_cluster_arbiter;
    localparam int NC = 8, NU = 5, WT = 3, WO = 6, NDF = 15, NUF = 5, WR = 32, WOPS = 96;

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [NC-1:0]      core_req_i = '0;
    logic [NC*WT-1:0]   core_type_i = '0;
    logic [NC*WO-1:0]   core_op_i = '0;
    logic [NC*WOPS-1:0] core_operands_i = '0;
    logic [NC*NDF-1:0]  core_flags_i = '0;
    logic [NC-1:0]      core_gnt_o, core_rvalid_o;
    logic [NC*WR-1:0]   core_result_o;
    logic [NC*NUF-1:0]  core_rflags_o;
    logic [NU-1:0]      unit_req_o, unit_rready_o;
    logic [NU*WO-1:0]   unit_op_o;
    logic [NU*WOPS-1:0] unit_operands_o;
    logic [NU*NDF-1:0]  unit_flags_o;
    logic [NU-1:0]      unit_gnt_i = '0;
    logic [NU-1:0]      unit_rvalid_i = '0;
    logic [NU*WR-1:0]   unit_result_i = '0;
    logic [NU*NUF-1:0]  unit_rflags_i = '0;
    logic               err_o;
    logic [7:0]         rr_exp [5] = '{8'h01, 8'h08, 8'h20, 8'h01, 8'h08};
    int                 n_cmp = 0, n_err = 0;

    always #5 clk_i = ~clk_i;

    apu_cluster_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_req_i(core_req_i), .core_type_i(core_type_i), .core_op_i(core_op_i),
        .core_operands_i(core_operands_i), .core_flags_i(core_flags_i),
        .core_gnt_o(core_gnt_o), .core_rvalid_o(core_rvalid_o),
        .core_result_o(core_result_o), .core_rflags_o(core_rflags_o),
        .unit_req_o(unit_req_o), .unit_op_o(unit_op_o), .unit_operands_o(unit_operands_o),
        .unit_flags_o(unit_flags_o), .unit_gnt_i(unit_gnt_i), .unit_rvalid_i(unit_rvalid_i),
        .unit_rready_o(unit_rready_o), .unit_result_i(unit_result_i),
        .unit_rflags_i(unit_rflags_i), .err_o(err_o)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #2;
    endtask

    task automatic req(input int c, input int t);
        core_req_i[c]               = 1'b1;
        core_type_i[c*WT +: WT]     = 3'(t);
        core_op_i[c*WO +: WO]       = 6'(c + 10);
        core_operands_i[c*WOPS +: WOPS] = {3{32'hA0000000 + 32'(c)}};
        core_flags_i[c*NDF +: NDF]  = 15'(c * 3 + 1);
    endtask

    initial begin
        #12;
        chk("rst_rvalid", core_rvalid_o, 0);
        chk("rst_req", unit_req_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_result", |core_result_o, 0);
        rst_i = 1'b0;
        tick;
        // single operation
        req(2, 1);
        unit_gnt_i[1] = 1'b1;
        #1;
        chk("s_unit_req", unit_req_o, 5'b00010);
        chk("s_gnt", core_gnt_o, 8'h04);
        chk("s_op", unit_op_o[6 +: 6], 6'd12);
        chk("s_opnd", unit_operands_o[96 +: 32], 32'hA0000002);
        chk("s_flags", unit_flags_o[15 +: 15], 15'd7);
        tick;
        core_req_i[2] = 1'b0;
        unit_gnt_i = '0;
        tick;
        unit_rvalid_i[1] = 1'b1;
        unit_result_i[32 +: 32] = 32'h3F800000;
        unit_rflags_i[5 +: 5] = 5'h3;
        #1;
        chk("s_rready", unit_rready_o, 5'h1F);
        tick;
        unit_rvalid_i = '0;
        chk("s_rvalid", core_rvalid_o, 8'h04);
        chk("s_result", core_result_o[64 +: 32], 32'h3F800000);
        chk("s_rflags", core_rflags_o[10 +: 5], 5'h3);
        tick;
        chk("s_pulse", core_rvalid_o, 0);
        chk("s_hold", core_result_o[64 +: 32], 32'h3F800000);
        // round-robin on unit 0 with responses draining in order
        req(0, 0); req(3, 0); req(5, 0);
        unit_gnt_i[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            unit_rvalid_i[0] = (i > 0);
            unit_result_i[0 +: 32] = 32'h100 + 32'(i);
            #1;
            chk($sformatf("rr_gnt%0d", i), core_gnt_o, rr_exp[i]);
            tick;
            if (i > 0) chk($sformatf("rr_rv%0d", i), core_rvalid_o, rr_exp[i-1]);
        end
        core_req_i = '0;
        unit_gnt_i = '0;
        unit_rvalid_i[0] = 1'b1;
        unit_result_i[0 +: 32] = 32'h105;
        tick;
        unit_rvalid_i = '0;
        chk("rr_rv5", core_rvalid_o, 8'h08);
        chk("rr_res", core_result_o[96 +: 32], 32'h105);
        // lock on unit 2
        req(4, 2);
        #1;
        chk("lk_req", unit_req_o, 5'b00100);
        chk("lk_op0", unit_op_o[12 +: 6], 6'd14);
        tick;
        req(1, 2);
        for (int i = 0; i < 2; i++) begin
            #1;
            chk($sformatf("lk_op%0d", i + 1), unit_op_o[12 +: 6], 6'd14);
            chk($sformatf("lk_nogrant%0d", i), core_gnt_o, 0);
            tick;
        end
        unit_gnt_i[2] = 1'b1;
        #1;
        chk("lk_gnt4", core_gnt_o, 8'h10);
        tick;
        core_req_i[4] = 1'b0;
        #1;
        chk("lk_gnt1", core_gnt_o, 8'h02);
        chk("lk_op1", unit_op_o[12 +: 6], 6'd11);
        tick;
        core_req_i = '0;
        unit_gnt_i = '0;
        unit_rvalid_i[2] = 1'b1;
        tick;
        chk("lk_rv4", core_rvalid_o, 8'h10);
        tick;
        unit_rvalid_i = '0;
        chk("lk_rv1", core_rvalid_o, 8'h02);
        // FIFO full on unit 3
        req(6, 3);
        unit_gnt_i[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("fu_gnt%0d", i), core_gnt_o, 8'h40);
            tick;
        end
        #1;
        chk("fu_req", unit_req_o[3], 1'b0);
        chk("fu_nogrant", core_gnt_o, 0);
        unit_rvalid_i[3] = 1'b1;
        #1;
        chk("fu_req_pop", unit_req_o[3], 1'b0);
        chk("fu_nogrant_pop", core_gnt_o, 0);
        tick;
        unit_rvalid_i = '0;
        chk("fu_rv", core_rvalid_o, 8'h40);
        #1;
        chk("fu_reissue", core_gnt_o, 8'h40);
        tick;
        core_req_i = '0;
        unit_gnt_i = '0;
        // collision: units 0 and 3 both answer core 6
        req(6, 0);
        unit_gnt_i[0] = 1'b1;
        #1;
        chk("co_gnt", core_gnt_o, 8'h40);
        tick;
        core_req_i = '0;
        unit_gnt_i = '0;
        unit_rvalid_i = 5'b01001;
        unit_result_i[0 +: 32] = 32'hAAAA0000;
        unit_result_i[96 +: 32] = 32'hBBBB0000;
        #1;
        chk("co_rready", unit_rready_o, 5'b10111);
        tick;
        unit_rvalid_i = 5'b01000;
        chk("co_rv0", core_rvalid_o, 8'h40);
        chk("co_res0", core_result_o[192 +: 32], 32'hAAAA0000);
        #1;
        chk("co_rready3", unit_rready_o, 5'h1F);
        tick;
        unit_rvalid_i = '0;
        chk("co_rv3", core_rvalid_o, 8'h40);
        chk("co_res3", core_result_o[192 +: 32], 32'hBBBB0000);
        // response with empty FIFO
        chk("er_pre", err_o, 0);
        unit_rvalid_i[4] = 1'b1;
        #1;
        chk("er_rready", unit_rready_o[4], 1'b1);
        tick;
        unit_rvalid_i = '0;
        chk("er_set", err_o, 1);
        chk("er_no_rv", core_rvalid_o, 0);
        tick;
        chk("er_sticky", err_o, 1);
        // asynchronous reset during traffic
        req(6, 3);
        unit_gnt_i[3] = 1'b1;
        #1;
        chk("rs_gnt_pre", core_gnt_o, 8'h40);
        rst_i = 1'b1;
        #1;
        chk("rs_req", unit_req_o, 0);
        chk("rs_gnt", core_gnt_o, 0);
        chk("rs_err", err_o, 0);
        chk("rs_rready", unit_rready_o, 0);
        chk("rs_op", unit_op_o, 0);
        chk("rs_result", core_result_o[192 +: 32], 0);
        rst_i = 1'b0;
        core_req_i = '0;
        unit_gnt_i = '0;
        tick;
        unit_rvalid_i[3] = 1'b1;
        #1;
        chk("rs_late_rready", unit_rready_o[3], 1'b1);
        tick;
        unit_rvalid_i = '0;
        chk("rs_late_err", err_o, 1);
        chk("rs_late_no_rv", core_rvalid_o, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
